// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath helpers (accumulator width, saturating signed resize).
package cnn_pkg;
  function automatic int acc_width(input int img, input int ker);
    return img + ker + 1;
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int out_width);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return (value > mx) ? mx : (value < mn) ? mn : value;
  endfunction
endpackage

// File: rtl/accum_post_fifo.sv
// accum_post_fifo: first-word fall-through sync FIFO; out_data keeps the last popped word while empty.
module accum_post_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_last;
  logic             w_wr, w_rd;
  always_comb begin
    full     = r_cnt == (AW+1)'(DEPTH);
    empty    = r_cnt == '0;
    w_rd     = pop & !empty;
    w_wr     = push & (!full | w_rd);
    out_data = empty ? r_last : r_mem[r_rp];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) begin
        r_rp   <= r_rp + AW'(1);
        r_last <= r_mem[r_rp];
      end
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= data_in;
endmodule

// File: rtl/accum_post.sv
// accum_post: MAC result + bias, rounding arithmetic shift, saturation into an output FIFO.
// Define ACCUM_POST_RELU_EN to clamp negative pixels to zero.
module accum_post
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH   = 16,
  parameter int KER_WIDTH   = 8,
  parameter int BIAS_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int DEPTH       = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic signed [BIAS_WIDTH-1:0]                         cfg_bias,
  input  logic        [SHIFT_WIDTH-1:0]                        cfg_shift,
  input  logic                                                 in_val,
  input  logic signed [acc_width(IMG_WIDTH, KER_WIDTH)-1:0]    in_result,
  output logic                                                 out_val,
  input  logic                                                 out_rdy,
  output logic signed [IMG_WIDTH-1:0]                          out_data,
  output logic                                                 overflow
);
  localparam int ACC_W = acc_width(IMG_WIDTH, KER_WIDTH);
  localparam int SW    = ACC_W + 1;
  localparam int XW    = SW + 1;
  logic                          r_v1, r_v2, r_v3, r_ovf;
  logic signed [SW-1:0]          r_sum1;
  logic        [SHIFT_WIDTH-1:0] r_sh1;
  logic signed [XW-1:0]          r_r2, w_ext, w_rnd, w_shr, w_r;
  logic signed [IMG_WIDTH-1:0]   r_d3, w_sat, w_px;
  logic                          w_full, w_empty, w_pop;
  always_comb begin
    w_ext = XW'(r_sum1);
    w_rnd = w_ext + (XW'(1) << (r_sh1 - SHIFT_WIDTH'(1)));
    w_shr = w_rnd >>> r_sh1;
    // shifting past the whole sum collapses to the sign: 0 or -1
    w_r   = (r_sh1 == '0) ? w_ext : (32'(r_sh1) >= SW) ? (r_sum1[SW-1] ? '1 : '0) : w_shr;
    w_sat = IMG_WIDTH'(sat_signed(64'(r_r2), IMG_WIDTH));
`ifdef ACCUM_POST_RELU_EN
    w_px  = w_sat[IMG_WIDTH-1] ? '0 : w_sat;
`else
    w_px  = w_sat;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_sum1 <= '0;
      r_sh1  <= '0;
      r_r2   <= '0;
      r_d3   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_v1   <= in_val;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_sum1 <= SW'(in_result) + SW'(cfg_bias);
      r_sh1  <= cfg_shift;
      r_r2   <= w_r;
      r_d3   <= w_px;
      r_ovf  <= r_ovf | (r_v3 & w_full & !w_pop);
    end
  accum_post_fifo #(.DEPTH(DEPTH), .WIDTH(IMG_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (r_v3),
    .data_in  (r_d3),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .out_data (out_data)
  );
  assign out_val  = !w_empty;
  assign w_pop    = out_val & out_rdy;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_accum_post.sv
// tb_accum_post: directed and randomized checks of accum_post against a queue-based reference model.
module tb_accum_post;
  localparam int IMG = 16, KER = 8, BW = 16, SHW = 5, DEPTH = 4;
  localparam int ACC = IMG + KER + 1, SW = ACC + 1;
  logic clk = 1'b0, rst = 1'b1;
  logic signed [BW-1:0]  cfg_bias = '0;
  logic [SHW-1:0]        cfg_shift = '0;
  logic                  in_val = 1'b0, out_rdy = 1'b0;
  logic signed [ACC-1:0] in_result = '0;
  logic                  out_val, overflow;
  logic signed [IMG-1:0] out_data;
  int n_run = 0, n_fail = 0;
  typedef struct {int due; longint val;} pend_t;

  always #5 clk = ~clk;

  accum_post dut (
    .clk(clk), .rst(rst), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .in_val(in_val),
    .in_result(in_result), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .overflow(overflow)
  );

  function automatic longint ref_px(input longint res, input longint bias, input int sh);
    longint s, r, mx, mn;
    s = res + bias;
    if (sh == 0) r = s;
    else if (sh >= SW) r = (s < 0) ? -1 : 0;
    else r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    mx = (64'sd1 <<< (IMG - 1)) - 1;
    mn = -(64'sd1 <<< (IMG - 1));
    r = (r > mx) ? mx : (r < mn) ? mn : r;
`ifdef ACCUM_POST_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input longint res, input longint bias, input int sh, input logic v);
    in_val = v;
    in_result = ACC'(res);
    cfg_bias = BW'(bias);
    cfg_shift = SHW'(sh);
  endtask

  task automatic single(input longint res, input longint bias, input int sh,
                        output logic v2, output logic v3, output logic signed [IMG-1:0] d);
    drive(res, bias, sh, 1'b1);
    out_rdy = 1'b1;
    tick;
    in_val = 1'b0;
    tick;
    tick;
    v2 = out_val;
    tick;
    v3 = out_val;
    d = out_data;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    n_run += 3;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b expected 0", out_val); end
    if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    tick;
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic v2, v3;
    logic signed [IMG-1:0] d;
    single(5, 0, 0, v2, v3, d);
    n_run += 3;
    if (v2 !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b expected 0", v2); end
    if (v3 !== 1'b1) begin n_fail++; $display("FAIL basic_val: got %b expected 1", v3); end
    if (d !== IMG'(ref_px(5, 0, 0))) begin n_fail++; $display("FAIL basic_data: got %0d expected %0d", d, ref_px(5, 0, 0)); end
  endtask

  task automatic test_table(input string nm, input longint res[], input longint bias[], input int sh[]);
    logic v2, v3;
    logic signed [IMG-1:0] d;
    longint e;
    foreach (res[i]) begin
      single(res[i], bias[i], sh[i], v2, v3, d);
      e = ref_px(res[i], bias[i], sh[i]);
      n_run += 2;
      if (v3 !== 1'b1) begin n_fail++; $display("FAIL %s_val[%0d]: got %b expected 1", nm, i, v3); end
      if (d !== IMG'(e)) begin n_fail++; $display("FAIL %s_data[%0d]: got %0d expected %0d", nm, i, d, e); end
    end
  endtask

  task automatic test_round;
    test_table("round", '{6, -7}, '{3, 3}, '{2, 2});
  endtask

  task automatic test_saturate;
    test_table("sat", '{40000, -40000, 32767, -32768}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
  endtask

  task automatic test_shift_edge;
    test_table("shedge", '{-100, 100, 16777215, -16777216, 1}, '{0, 0, 32767, -32768, 0}, '{26, 31, 25, 25, 1});
  endtask

  task automatic test_stream;
    out_rdy = 1'b1;
    drive(1, 0, 0, 1'b1);
    for (int c = 0; c <= 13; c++) begin
      tick;
      if (c + 1 < 10) drive(c + 2, 0, 0, 1'b1); else in_val = 1'b0;
      if (c >= 3 && c <= 12) begin
        n_run += 2;
        if (out_val !== 1'b1) begin n_fail++; $display("FAIL stream_val[%0d]: got %b expected 1", c, out_val); end
        if (out_data !== IMG'(ref_px(c - 2, 0, 0))) begin
          n_fail++; $display("FAIL stream_data[%0d]: got %0d expected %0d", c, out_data, ref_px(c - 2, 0, 0));
        end
      end
    end
    n_run += 2;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL stream_end: got %b expected 0", out_val); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow;
    out_rdy = 1'b0;
    drive(1, 0, 0, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      tick;
      if (c + 1 < 6) drive(c + 2, 0, 0, 1'b1); else in_val = 1'b0;
      if (c == 6) begin
        n_run++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full_early: got %b expected 0", overflow); end
      end
    end
    n_run++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    out_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_run += 2;
      if (out_val !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_val[%0d]: got %b expected 1", k, out_val); end
      if (out_data !== IMG'(k)) begin n_fail++; $display("FAIL ovf_drain_data[%0d]: got %0d expected %0d", k, out_data, k); end
      tick;
    end
    n_run += 3;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", out_val); end
    if (out_data !== 16'sd4) begin n_fail++; $display("FAIL ovf_hold: got %0d expected 4", out_data); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_midop;
    logic v2, v3;
    logic signed [IMG-1:0] d;
    out_rdy = 1'b0;
    drive(1, 0, 0, 1'b1);
    for (int c = 0; c <= 5; c++) begin
      tick;
      if (c + 1 < 5) drive(c + 2, 0, 0, 1'b1); else in_val = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_run += 3;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL midrst_val: got %b expected 0", out_val); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b expected 0", overflow); end
    if (out_data !== 16'sd0) begin n_fail++; $display("FAIL midrst_data: got %0d expected 0", out_data); end
    tick;
    tick;
    rst = 1'b1;
    out_rdy = 1'b1;
    repeat (4) tick;
    n_run++;
    if (out_val !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got %b expected 0", out_val); end
    single(7, 0, 0, v2, v3, d);
    n_run += 3;
    if (v2 !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %b expected 0", v2); end
    if (v3 !== 1'b1) begin n_fail++; $display("FAIL midrst_new_val: got %b expected 1", v3); end
    if (d !== 16'sd7) begin n_fail++; $display("FAIL midrst_new_data: got %0d expected 7", d); end
  endtask

  task automatic test_random;
    longint q[$];
    pend_t pend[$];
    pend_t p;
    longint res, bias, last, e;
    logic iv, rdy, popm, ovf;
    int sh, cyc;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    q = {};
    pend = {};
    last = 0;
    ovf = 1'b0;
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      iv = $urandom_range(0, 9) < 7;
      rdy = $urandom_range(0, 9) < 6;
      res = ($urandom_range(0, 2) == 0) ? longint'($signed(ACC'($urandom))) : longint'($urandom_range(0, 4000)) - 2000;
      bias = ($urandom_range(0, 1) == 0) ? longint'($signed(BW'($urandom))) : longint'($urandom_range(0, 200)) - 100;
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      drive(res, bias, sh, iv);
      out_rdy = rdy;
      popm = (q.size() > 0) && rdy;
      tick;
      cyc++;
      if (popm) last = q.pop_front();
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (q.size() < DEPTH) q.push_back(p.val); else ovf = 1'b1;
      end
      if (iv) pend.push_back('{cyc + 3, ref_px(res, bias, sh)});
      e = (q.size() > 0) ? q[0] : last;
      n_run += 3;
      if (out_val !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_val[%0d]: got %b expected %b", n, out_val, q.size() > 0); end
      if (out_data !== IMG'(e)) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0d expected %0d", n, out_data, e); end
      if (overflow !== ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", n, overflow, ovf); end
    end
    in_val = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round;
    test_saturate;
    test_shift_edge;
    test_stream;
    test_overflow;
    test_reset_midop;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
